// File: rtl/lynx_clk_rst_seq.sv
// Lynx 48 clock/reset sequencer: qualifies PLL lock, sequences the core reset
// and generates the CPU phase enables and the pixel enable on the 32 MHz clock.
module lynx_clk_rst_seq #(
    parameter int LOCK_STABLE = 1024,
    parameter int RST_HOLD    = 64,
    parameter int CPU_DIV     = 8,
    parameter int TURBO_DIV   = 4,
    parameter int PIX_DIV     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_locked,
    input  logic soft_reset,
    input  logic turbo,
    input  logic cpu_wait,
    output logic reset_out,
    output logic ce_cpu,
    output logic ce_cpu_n,
    output logic ce_pix,
    output logic ready
);
    localparam int MAXD = (CPU_DIV > TURBO_DIV) ? CPU_DIV : TURBO_DIV;
    localparam int CW   = $clog2(MAXD);
    localparam int DW   = CW + 1;
    localparam int PW   = $clog2(PIX_DIV);
    localparam int LW   = $clog2(LOCK_STABLE);
    localparam int HW   = $clog2(RST_HOLD);

    typedef enum logic [1:0] {WAIT_LOCK, STABLE, HOLD, RUN} state_t;

    state_t        state;
    logic          lk_m, lk_s;
    logic [LW-1:0] lock_cnt;
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] cc;
    logic [DW-1:0] d;
    logic [PW-1:0] pc;
    logic          running, cc_last, cc_half, pc_last;
    logic [DW-1:0] d_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= pll_locked;
            lk_s <= lk_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            lock_cnt  <= '0;
            hold_cnt  <= '0;
            reset_out <= 1'b1;
            ready     <= 1'b0;
        end else begin
            reset_out <= 1'b1;
            ready     <= 1'b0;
            case (state)
                WAIT_LOCK: begin
                    lock_cnt <= '0;
                    hold_cnt <= '0;
                    if (lk_s) state <= STABLE;
                end
                STABLE: begin
                    if (!lk_s) begin
                        state    <= WAIT_LOCK;
                        lock_cnt <= '0;
                    end else if (lock_cnt == LW'(LOCK_STABLE - 1)) begin
                        state    <= HOLD;
                        lock_cnt <= '0;
                        hold_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
                HOLD: begin
                    if (!lk_s) begin
                        state <= WAIT_LOCK;
                    end else if (soft_reset) begin
                        hold_cnt <= '0;
                    end else if (hold_cnt == HW'(RST_HOLD - 1)) begin
                        state     <= RUN;
                        reset_out <= 1'b0;
                        ready     <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RUN: begin
                    // Lock loss outranks a simultaneous soft reset.
                    if (!lk_s) begin
                        state <= WAIT_LOCK;
                    end else if (soft_reset) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else begin
                        reset_out <= 1'b0;
                        ready     <= 1'b1;
                    end
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

    // Gating with lk_s silences the enables on the same edge the FSM drops out.
    always_comb begin
        running = ((state == HOLD) || (state == RUN)) && lk_s;
        d_sel   = turbo ? DW'(TURBO_DIV) : DW'(CPU_DIV);
        cc_last = (DW'(cc) == d - DW'(1));
        cc_half = (DW'(cc) == (d >> 1) - DW'(1));
        pc_last = (pc == PW'(PIX_DIV - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc       <= '0;
            d        <= DW'(CPU_DIV);
            pc       <= '0;
            ce_cpu   <= 1'b0;
            ce_cpu_n <= 1'b0;
            ce_pix   <= 1'b0;
        end else if (!running) begin
            cc       <= '0;
            d        <= d_sel;
            pc       <= '0;
            ce_cpu   <= 1'b0;
            ce_cpu_n <= 1'b0;
            ce_pix   <= 1'b0;
        end else begin
            ce_pix   <= pc_last;
            pc       <= pc_last ? '0 : pc + PW'(1);
            ce_cpu   <= !cpu_wait && cc_last;
            ce_cpu_n <= !cpu_wait && cc_half;
            // The divisor is only re-sampled at a wrap, so turbo never makes a runt period.
            if (!cpu_wait) begin
                if (cc_last) begin
                    cc <= '0;
                    d  <= d_sel;
                end else begin
                    cc <= cc + CW'(1);
                end
            end
        end
    end
endmodule
